// File: rtl/serial_subtractor_32bit.sv
// Bit-serial two's-complement subtractor: result = a - b, one bit per cycle, LSB first.
// A single full adder computes a + ~b + 1; the flags are captured on the final bit.
module serial_subtractor_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             sum, c_next, last_bit;

  assign sum      = a_q[0] ^ nb_q[0] ^ carry_q;
  assign c_next   = (a_q[0] & nb_q[0]) | (a_q[0] & carry_q) | (nb_q[0] & carry_q);
  assign last_bit = (count_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    nb_d        = nb_q;
    acc_d       = acc_q;
    result_d    = result_q;
    count_d     = count_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // Subtraction as a + ~b with the initial carry standing in for the +1.
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          count_d = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        nb_d    = nb_q >> 1;
        carry_d = c_next;
        count_d = count_q + 1'b1;
        acc_d   = {sum, acc_q[WIDTH-1:1]};
        if (last_bit) begin
          // Visible outputs change only here so the consumer never sees a partial value.
          result_d    = {sum, acc_q[WIDTH-1:1]};
          carry_out_d = c_next;
          overflow_d  = carry_q ^ c_next;
          state_d     = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      nb_q        <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Directed-vector bench for serial_subtractor_32bit: latency, flags, handshake and reset.
module tb_serial_subtractor_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] prev_result = '0;

  serial_subtractor_32bit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Count edges after the accepting edge until done is seen (bounded at 100).
  // Optionally pulse start with junk operands at a given cycle and check result holds mid-run.
  task automatic wait_done(output int lat, input int pulse_at);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 16) check("result_hold_midrun", result, prev_result);
      if (pulse_at >= 0 && lat == pulse_at) begin
        start = 1'b1;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
      end
      if (pulse_at >= 0 && lat == pulse_at + 1) start = 1'b0;
    end while (!done && lat < 100);
  endtask

  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic ec, input logic ev,
                        input int pulse_at);
    int lat;
    launch(av, bv);
    wait_done(lat, pulse_at);
    check({tag, "_latency"}, lat, 32'd32);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, result, er);
    check({tag, "_carry_out"}, {31'd0, carry_out}, {31'd0, ec});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ev});
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_result_stable"}, result, er);
    prev_result = er;
  endtask

  initial begin
    int lat;
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_carry_out", {31'd0, carry_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("sub_5_3", 32'd5, 32'd3, 32'd2, 1'b1, 1'b0, -1);
    run_op("equal", 32'h0000_0001, 32'h0000_0001, 32'd0, 1'b1, 1'b0, -1);
    run_op("min_minus_1", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, -1);
    run_op("zero_minus_1", 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    run_op("b_zero", 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 1'b0, -1);
    run_op("max_minus_neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, -1);

    // start during RUN must not relatch the new operands
    run_op("ignore_start", 32'd100, 32'd58, 32'd42, 1'b1, 1'b0, 10);

    // Asynchronous reset mid-run clears everything immediately
    launch(32'd9, 32'd4);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_carry_out", {31'd0, carry_out}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    #10;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 32'd0);
    prev_result = '0;
    run_op("after_rst", 32'd9, 32'd4, 32'd5, 1'b1, 1'b0, -1);

    // start held high: back-to-back ops every 33 cycles
    a     = 32'd20;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat, -1);
    check("b2b_first_latency", lat, 32'd32);
    check("b2b_first_result", result, 32'd13);
    prev_result = 32'd13;
    @(posedge clk);
    #1;
    check("b2b_busy_after_done", {31'd0, busy}, 32'd1);
    wait_done(lat, -1);
    check("b2b_period", lat + 1, 32'd33);
    check("b2b_second_result", result, 32'd13);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_idle", {31'd0, busy | done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
